// File: rtl/eth_bus_pkg.sv
// Shared definitions for the Ethernet bus sequencer and the bus muxes that decode its ctl output.
// The state encodings double as the bus-mux select values.
package eth_bus_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'b000,
        ST_TX_INIT = 3'b001,
        ST_TX      = 3'b010,
        ST_RX_INIT = 3'b011,
        ST_RX      = 3'b100,
        ST_IDLE    = 3'b111
    } eth_bus_state_e;

    localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd50000;

    function automatic logic is_tx_path(input eth_bus_state_e s);
        return (s == ST_TX_INIT) || (s == ST_TX);
    endfunction

    function automatic logic is_rx_path(input eth_bus_state_e s);
        return (s == ST_RX_INIT) || (s == ST_RX);
    endfunction

endpackage

// File: rtl/eth_bus_watchdog.sv
// Residency watchdog for the sequencer.
// The count saturates at all-ones rather than wrapping.
module eth_bus_watchdog
    import eth_bus_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic expire
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear, otherwise increment up to saturation.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 16'd0;
        end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = active && (count_q == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/eth_bus_sequencer.sv
// Ethernet bus sequencer: arbitrates the chip bus between init, transmit and receive phases.
// Define ETH_BUS_WATCHDOG_EN to add a per-state residency watchdog.
module eth_bus_sequencer
    import eth_bus_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       reinit,
    input  logic       tx_req,
    input  logic       rx_req,
    input  logic       txi_done,
    input  logic       tx_done,
    input  logic       rxi_done,
    input  logic       rx_done,
    output logic [2:0] ctl,
    output logic       tx_grant,
    output logic       rx_grant,
    output logic       timeout_err
);

    eth_bus_state_e state_q, state_d, nat_d;
    logic           last_rx_q, last_rx_d;
    logic           tx_grant_q, rx_grant_q;
    logic           expire_s;
    logic           timeout_s;

    // Phase sequencing without the watchdog; stray done pulses fall through to hold.
    always_comb begin
        nat_d = state_q;
        case (state_q)
            ST_INIT:    if (init_done) nat_d = ST_IDLE;    else nat_d = ST_INIT;
            ST_TX_INIT: if (txi_done)  nat_d = ST_TX;      else nat_d = ST_TX_INIT;
            ST_TX:      if (tx_done)   nat_d = ST_IDLE;    else nat_d = ST_TX;
            ST_RX_INIT: if (rxi_done)  nat_d = ST_RX;      else nat_d = ST_RX_INIT;
            ST_RX:      if (rx_done)   nat_d = ST_IDLE;    else nat_d = ST_RX;
            ST_IDLE: begin
                if (reinit)                 nat_d = ST_INIT;
                else if (tx_req && rx_req)  nat_d = last_rx_q ? ST_TX_INIT : ST_RX_INIT;
                else if (tx_req)            nat_d = ST_TX_INIT;
                else if (rx_req)            nat_d = ST_RX_INIT;
                else                        nat_d = ST_IDLE;
            end
            default:    nat_d = ST_IDLE;
        endcase
    end

    // Expiry only wins when no done pulse is moving the state this cycle.
    always_comb begin
        timeout_s = expire_s && (nat_d == state_q);
        if (timeout_s) begin
            state_d = ST_INIT;
        end else begin
            state_d = nat_d;
        end
    end

    // Round-robin bit follows entry into either setup phase.
    always_comb begin
        last_rx_d = last_rx_q;
        if ((state_d == ST_TX_INIT) && (state_q != ST_TX_INIT)) begin
            last_rx_d = 1'b0;
        end else if ((state_d == ST_RX_INIT) && (state_q != ST_RX_INIT)) begin
            last_rx_d = 1'b1;
        end else begin
            last_rx_d = last_rx_q;
        end
    end

    // State, arbitration and grant registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            last_rx_q  <= 1'b0;
            tx_grant_q <= 1'b0;
            rx_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_rx_q  <= last_rx_d;
            tx_grant_q <= is_tx_path(state_d);
            rx_grant_q <= is_rx_path(state_d);
        end
    end

    assign ctl      = state_q;
    assign tx_grant = tx_grant_q;
    assign rx_grant = rx_grant_q;

`ifdef ETH_BUS_WATCHDOG_EN
    logic timeout_err_q;
    logic wd_clear_s;
    logic wd_active_s;

    assign wd_active_s = (state_q != ST_IDLE);
    assign wd_clear_s  = (state_d != state_q) || (state_q == ST_IDLE) || timeout_s;

    eth_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (wd_clear_s),
        .active (wd_active_s),
        .expire (expire_s)
    );

    // Timeout pulse lines up with the first Init cycle after expiry.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_s;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign expire_s         = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_bus_sequencer.sv
// Scoreboard bench for eth_bus_sequencer; stimulus queues per-cycle expectations, a monitor checks them.
// Covers both builds, with and without ETH_BUS_WATCHDOG_EN.
module tb_eth_bus_sequencer;

    logic       sysclk;
    logic       reset;
    logic       init_done, reinit, tx_req, rx_req;
    logic       txi_done, tx_done, rxi_done, rx_done;
    logic [2:0] ctl;
    logic       tx_grant, rx_grant, timeout_err;

    typedef struct packed {
        int         cyc;
        logic [2:0] ctl;
        logic       tx;
        logic       rx;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    event  sample_ev;

    eth_bus_sequencer #(.TIMEOUT_CYCLES(16'd8)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .init_done   (init_done),
        .reinit      (reinit),
        .tx_req      (tx_req),
        .rx_req      (rx_req),
        .txi_done    (txi_done),
        .tx_done     (tx_done),
        .rxi_done    (rxi_done),
        .rx_done     (rx_done),
        .ctl         (ctl),
        .tx_grant    (tx_grant),
        .rx_grant    (rx_grant),
        .timeout_err (timeout_err)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic expect_now(input logic [2:0] c, input logic t, input logic r,
                              input logic e, input string nm);
        exp_t x;
        x.cyc = cyc;
        x.ctl = c;
        x.tx  = t;
        x.rx  = r;
        x.err = e;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic [2:0] c, input logic t, input logic r,
                        input logic e, input string nm);
        expect_now(c, t, r, e, nm);
        @(posedge sysclk);
        #1;
    endtask

    // Monitor: compare every queued expectation belonging to the current cycle.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(negedge sysclk or sample_ev);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (x.cyc != cyc || ctl !== x.ctl || tx_grant !== x.tx ||
                    rx_grant !== x.rx || timeout_err !== x.err) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got ctl=%b tx=%b rx=%b err=%b, required ctl=%b tx=%b rx=%b err=%b (cyc %0d)",
                             nm, cyc, ctl, tx_grant, rx_grant, timeout_err,
                             x.ctl, x.tx, x.rx, x.err, x.cyc);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        {init_done, reinit, tx_req, rx_req} = 4'b0000;
        {txi_done, tx_done, rxi_done, rx_done} = 4'b0000;
        @(posedge sysclk);
        #1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "reset0");
        step(3'b000, 1'b0, 1'b0, 1'b0, "reset1");

        // Release, init_done at cycle 5.
        reset = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            init_done = (i == 5);
            step(3'b000, 1'b0, 1'b0, 1'b0, "init_wait");
        end
        init_done = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "init_to_idle");

        // Single transmit, request dropped on entry, stray done pulses ignored.
        tx_req = 1'b1;
        step(3'b111, 1'b0, 1'b0, 1'b0, "tx_idle");
        tx_req = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            txi_done = (k == 3);
            tx_done  = (k == 2) || (k == 10);
            rx_done  = (k == 1);
            rxi_done = (k == 5);
            step((k <= 3) ? 3'b001 : 3'b010, 1'b1, 1'b0, 1'b0, "tx_phase");
        end
        {txi_done, tx_done, rxi_done, rx_done} = 4'b0000;
        step(3'b111, 1'b0, 1'b0, 1'b0, "tx_done_idle");

        // Tie held for three transactions: Receive, Transmit, Receive.
        tx_req = 1'b1;
        rx_req = 1'b1;
        step(3'b111, 1'b0, 1'b0, 1'b0, "tie_idle0");
        rxi_done = 1'b1; step(3'b011, 1'b0, 1'b1, 1'b0, "tie_rxi1");
        rxi_done = 1'b0; rx_done = 1'b1; step(3'b100, 1'b0, 1'b1, 1'b0, "tie_rx1");
        rx_done = 1'b0;  step(3'b111, 1'b0, 1'b0, 1'b0, "tie_idle1");
        txi_done = 1'b1; step(3'b001, 1'b1, 1'b0, 1'b0, "tie_txi2");
        txi_done = 1'b0; tx_done = 1'b1; step(3'b010, 1'b1, 1'b0, 1'b0, "tie_tx2");
        tx_done = 1'b0;  step(3'b111, 1'b0, 1'b0, 1'b0, "tie_idle2");
        rxi_done = 1'b1; step(3'b011, 1'b0, 1'b1, 1'b0, "tie_rxi3");
        rxi_done = 1'b0; rx_done = 1'b1; step(3'b100, 1'b0, 1'b1, 1'b0, "tie_rx3");
        rx_done = 1'b0;
        tx_req = 1'b0;
        rx_req = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "tie_idle3");

        // Reinit beats a pending transmit request.
        reinit = 1'b1;
        tx_req = 1'b1;
        step(3'b111, 1'b0, 1'b0, 1'b0, "reinit_idle");
        reinit = 1'b0;
        tx_req = 1'b0;
        step(3'b000, 1'b0, 1'b0, 1'b0, "reinit_init");
        init_done = 1'b1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "reinit_init2");
        init_done = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "reinit_idle2");

        // Receive_Init with no rxi_done.
        rx_req = 1'b1;
        step(3'b111, 1'b0, 1'b0, 1'b0, "wd_idle");
        rx_req = 1'b0;
`ifdef ETH_BUS_WATCHDOG_EN
        for (int k = 0; k < 8; k++) begin
            step(3'b011, 1'b0, 1'b1, 1'b0, "wd_rxi");
        end
        step(3'b000, 1'b0, 1'b0, 1'b1, "wd_expire");
        step(3'b000, 1'b0, 1'b0, 1'b0, "wd_err_clear");
        init_done = 1'b1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "wd_init");
        init_done = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "wd_idle_end");
`else
        for (int k = 0; k < 100; k++) begin
            step(3'b011, 1'b0, 1'b1, 1'b0, "no_wd_hold");
        end
        rxi_done = 1'b1;
        step(3'b011, 1'b0, 1'b1, 1'b0, "no_wd_rxi");
        rxi_done = 1'b0;
        rx_done  = 1'b1;
        step(3'b100, 1'b0, 1'b1, 1'b0, "no_wd_rx");
        rx_done = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "no_wd_idle");
`endif

        // Asynchronous reset during Transmit.
        tx_req = 1'b1;
        step(3'b111, 1'b0, 1'b0, 1'b0, "ar_idle");
        tx_req   = 1'b0;
        txi_done = 1'b1;
        step(3'b001, 1'b1, 1'b0, 1'b0, "ar_txi");
        txi_done = 1'b0;
        expect_now(3'b010, 1'b1, 1'b0, 1'b0, "ar_tx");
        @(negedge sysclk);
        #1;
        reset = 1'b0;
        #1;
        expect_now(3'b000, 1'b0, 1'b0, 1'b0, "ar_async");
        ->sample_ev;
        @(posedge sysclk);
        #1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "ar_hold");
        reset = 1'b1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "ar_release");
        init_done = 1'b1;
        step(3'b000, 1'b0, 1'b0, 1'b0, "ar_init");
        init_done = 1'b0;
        step(3'b111, 1'b0, 1'b0, 1'b0, "ar_idle_end");

        @(negedge sysclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_bus_sequencer.md
ETH_BUS_SEQUENCER -- requirements
Module: eth_bus_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, giving the maximum cycles allowed in any non-Idle state.
REQ-002 The block SHALL have port sysclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port init_done, input, 1, chip initialisation finished (level).
REQ-005 The block SHALL have port reinit, input, 1, request to re-run initialisation (level).
REQ-006 The block SHALL have port tx_req, input, 1, a frame is waiting to transmit (level).
REQ-007 The block SHALL have port rx_req, input, 1, chip reports a received frame pending (level).
REQ-008 The block SHALL have ports txi_done, tx_done, rxi_done and rx_done, input, 1 each, phase-complete pulses from the transmit-setup, transmit, receive-setup and receive engines.
REQ-009 The block SHALL have port ctl, output, 3, bus-mux select encoding the current state.
REQ-010 The block SHALL have ports tx_grant and rx_grant, output, 1 each, high while the matching path owns the bus.
REQ-011 The block SHALL have port timeout_err, output, 1, one-cycle pulse on a watchdog expiry.

Function
REQ-012 The state register SHALL drive ctl directly, with encodings Init=000, Transmit_Init=001, Transmit=010, Receive_Init=011, Receive=100, Idle=111; unused codes SHALL decode as Idle on the next cycle.
REQ-013 Init SHALL go to Idle on the first cycle init_done=1.
REQ-014 Idle SHALL go to Init when reinit=1; reinit SHALL take priority over tx_req and rx_req.
REQ-015 From Idle with exactly one of tx_req or rx_req high, the block SHALL enter Transmit_Init or Receive_Init respectively.
REQ-016 From Idle with tx_req and rx_req both high, the block SHALL grant the path not served last (round-robin bit last_rx, reset 0, so the first tie goes to Receive).
REQ-017 last_rx SHALL update on entry to Transmit_Init (to 0) and on entry to Receive_Init (to 1).
REQ-018 The phase transitions SHALL be: Transmit_Init->Transmit on txi_done; Transmit->Idle on tx_done; Receive_Init->Receive on rxi_done; Receive->Idle on rx_done.
REQ-019 A done pulse arriving in a state other than its own SHALL be ignored.
REQ-020 Each transition SHALL take exactly one cycle, and Idle SHALL last at least one cycle between bus transactions.
REQ-021 tx_grant SHALL be 1 only in Transmit_Init and Transmit, and rx_grant only in Receive_Init and Receive; both SHALL be registered-state decodes with no input-to-output combinational path.
REQ-022 A request dropped mid-transaction SHALL NOT abort it; only a done pulse or the watchdog SHALL exit the state.

Reset
REQ-023 While reset=0, the block SHALL hold state=Init (ctl=000), tx_grant=0, rx_grant=0, timeout_err=0, last_rx=0 and watchdog count=0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion pulse required.
REQ-025 On release, the block SHALL re-enter Init and wait for init_done.

Configuration
REQ-026 With ETH_BUS_WATCHDOG_EN defined, a 16-bit counter SHALL clear on every state change and in Idle, and increment each cycle otherwise.
REQ-027 With ETH_BUS_WATCHDOG_EN defined, when the count reaches TIMEOUT_CYCLES-1 in any non-Idle state, the next state SHALL be Init, timeout_err SHALL pulse one cycle, and the counter SHALL saturate and never wrap.
REQ-028 With ETH_BUS_WATCHDOG_EN defined, a done pulse and expiry in the same cycle SHALL favour the done pulse.
REQ-029 Without ETH_BUS_WATCHDOG_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and the block SHALL wait indefinitely in each state.

Structure
REQ-030 A shared package eth_bus_pkg SHALL hold the 3-bit state encodings (used by this block and the bus muxes) and the default TIMEOUT_CYCLES.
REQ-031 The watchdog SHALL be the single sub-module eth_bus_watchdog (inputs clear and active; output expire), instantiated only under the macro.

Verification
REQ-032 Bench SHALL cover: reset release, init_done=1 at cycle 5 -> ctl 000 through cycle 5, 111 at cycle 6.
REQ-033 Bench SHALL cover: Idle, tx_req=1, txi_done at +3, tx_done at +10 -> ctl 001,010,111 with tx_grant high exactly 11 cycles.
REQ-034 Bench SHALL cover: tx_req=rx_req=1 held across three transactions -> order Receive, Transmit, Receive, with Idle for one cycle between each.
REQ-035 Bench SHALL cover: reinit=1 with tx_req=1 in Idle -> ctl 000 next cycle, tx_grant stays 0.
REQ-036 Bench SHALL cover: with the macro and TIMEOUT_CYCLES=8, Receive_Init with no rxi_done -> ctl 000 eight cycles after entry, timeout_err one-cycle pulse; without the macro -> stays 011 for 100 cycles.
REQ-037 Bench SHALL cover: reset pulsed low during Transmit -> ctl 000 and tx_grant 0 within the same cycle (asynchronous).
